// File: rtl/button_event_arbiter.sv
// Push-button gesture classifier (SHORT / LONG / DOUBLE) with round-robin
// arbitration of per-button events into a show-ahead valid/ready FIFO.

module button_event_fsm #(
  parameter int LONG_CYC = 50000000,
  parameter int DBL_CYC  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       down,
  input  logic       up,
  input  logic       grant,
  output logic       pend_vld,
  output logic [1:0] pend_code,
  output logic       ovf
);
  localparam int CNT_W = $clog2(LONG_CYC + 1);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYC - 1);
  localparam logic [1:0] C_SHORT = 2'd1;
  localparam logic [1:0] C_LONG  = 2'd2;
  localparam logic [1:0] C_DBL   = 2'd3;

  typedef enum logic [1:0] {IDLE, PRESS, GAP, WAIT_UP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             emit;
  logic [1:0]       emit_code;

  // Each state watches a single input; the edge input wins over a terminal count.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_code = 2'd0;
    case (state)
      IDLE:    if (down) state_nxt = PRESS;
      PRESS:   if (up) state_nxt = GAP;
               else if (cnt == LONG_TC) begin
                 emit = 1'b1; emit_code = C_LONG; state_nxt = WAIT_UP;
               end
      GAP:     if (down) begin
                 emit = 1'b1; emit_code = C_DBL; state_nxt = WAIT_UP;
               end else if (cnt == DBL_TC) begin
                 emit = 1'b1; emit_code = C_SHORT; state_nxt = IDLE;
               end
      WAIT_UP: if (up) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_vld  <= 1'b0;
      pend_code <= 2'd0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                 cnt <= '0;
      else if (state == PRESS || state == GAP) cnt <= cnt + 1'b1;
      // A grant frees the slot in the same cycle, so a concurrent emit is not a drop.
      ovf <= emit && pend_vld && !grant;
      if (emit && (!pend_vld || grant)) begin
        pend_vld  <= 1'b1;
        pend_code <= emit_code;
      end else if (grant) begin
        pend_vld  <= 1'b0;
        pend_code <= 2'd0;
      end
    end
  end
endmodule

module button_event_arbiter #(
  parameter int N_BTN      = 5,
  parameter int LONG_CYC   = 50000000,
  parameter int DBL_CYC    = 25000000,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_down_i,
  input  logic [N_BTN-1:0] btn_up_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [ID_W-1:0]  evt_id_o,
  output logic [1:0]       evt_code_o,
  output logic             overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      code;
  } evt_t;

  evt_t [FIFO_DEPTH-1:0]   mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic [N_BTN-1:0]        pend_vld, grant, ovf;
  logic [N_BTN-1:0][1:0]   pend_code;
  logic [ID_W-1:0]         rr_ptr, gnt_id, idx;
  logic                    gnt_any, push, pop;
  int                      sum;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    button_event_fsm #(.LONG_CYC(LONG_CYC), .DBL_CYC(DBL_CYC)) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .down     (btn_down_i[g]),
      .up       (btn_up_i[g]),
      .grant    (grant[g]),
      .pend_vld (pend_vld[g]),
      .pend_code(pend_code[g]),
      .ovf      (ovf[g])
    );
  end

  // First pending button at or above the RR pointer, wrapping; none while full.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    grant   = '0;
    idx     = '0;
    sum     = 0;
    if (count != CW'(FIFO_DEPTH)) begin
      for (int i = 0; i < N_BTN; i++) begin
        sum = int'(rr_ptr) + i;
        if (sum >= N_BTN) sum = sum - N_BTN;
        idx = ID_W'(sum);
        if (!gnt_any && pend_vld[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  assign push = gnt_any;
  assign pop  = evt_valid_o && evt_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {gnt_id, pend_code[gnt_id]};
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign evt_valid_o = (count != '0);
  assign evt_id_o    = mem[rd_ptr].id;
  assign evt_code_o  = mem[rd_ptr].code;
  assign overflow_o  = |ovf;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: timestamp-based gesture model,
// queue-based FIFO model, per-cycle compare plus literal timing pins.

module tb_button_event_arbiter;
  localparam int N    = 3;
  localparam int LONG = 16;
  localparam int DBL  = 8;
  localparam int DEP  = 2;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  btn_down_i = '0;
  logic [N-1:0]  btn_up_i   = '0;
  logic          evt_ready_i = 1'b1;
  logic          evt_valid_o;
  logic [IW-1:0] evt_id_o;
  logic [1:0]    evt_code_o;
  logic          overflow_o;

  button_event_arbiter #(
    .N_BTN(N), .LONG_CYC(LONG), .DBL_CYC(DBL), .FIFO_DEPTH(DEP), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .btn_down_i(btn_down_i), .btn_up_i(btn_up_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_id_o(evt_id_o),
    .evt_code_o(evt_code_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_del = 0;
  int n_ovf = 0;

  // Model: gestures as phases with timestamps, pending slots, FIFO as a queue.
  int  ph  [N];
  int  tdn [N];
  int  tup [N];
  bit  pv  [N];
  int  pc  [N];
  int  q   [$];
  int  rr;
  bit  m_ovf;
  int  mcyc = 0;
  bit  started = 0;

  always @(posedge clk) begin
    int g;
    bit e;
    int ec;
    if (started && !rst && evt_valid_o && evt_ready_i) n_del++;
    if (rst) begin
      for (int b = 0; b < N; b++) begin ph[b] = 0; pv[b] = 0; pc[b] = 0; end
      q.delete();
      rr = 0;
      m_ovf = 0;
    end else begin
      g = -1;
      if (q.size() < DEP)
        for (int i = 0; i < N; i++)
          if (g < 0 && pv[(rr + i) % N]) g = (rr + i) % N;
      if (q.size() != 0 && evt_ready_i) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back(g * 4 + pc[g]);
        pv[g] = 0;
        rr = (g + 1) % N;
      end
      m_ovf = 0;
      for (int b = 0; b < N; b++) begin
        e = 0; ec = 0;
        case (ph[b])
          0: if (btn_down_i[b]) begin ph[b] = 1; tdn[b] = mcyc; end
          1: if (btn_up_i[b]) begin ph[b] = 2; tup[b] = mcyc; end
             else if (mcyc == tdn[b] + LONG) begin e = 1; ec = 2; ph[b] = 3; end
          2: if (btn_down_i[b]) begin e = 1; ec = 3; ph[b] = 3; end
             else if (mcyc == tup[b] + DBL) begin e = 1; ec = 1; ph[b] = 0; end
          default: if (btn_up_i[b]) ph[b] = 0;
        endcase
        if (e) begin
          if (pv[b]) m_ovf = 1;
          else begin pv[b] = 1; pc[b] = ec; end
        end
      end
    end
    mcyc++;
    started = 1;
  end

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("valid", int'(evt_valid_o), int'(q.size() != 0));
      if (q.size() != 0 && evt_valid_o) begin
        check("id", int'(evt_id_o), q[0] / 4);
        check("code", int'(evt_code_o), q[0] % 4);
      end
      check("overflow", int'(overflow_o), int'(m_ovf));
      if (overflow_o) n_ovf++;
    end
  end

  // Hand-computed pin: checks both DUT and model against a literal.
  task automatic lit(string nm, bit v, int id, int code);
    check({nm, "_valid"}, int'(evt_valid_o), int'(v));
    check({nm, "_mvalid"}, int'(q.size() != 0), int'(v));
    if (v) begin
      check({nm, "_id"}, int'(evt_id_o), id);
      check({nm, "_code"}, int'(evt_code_o), code);
      if (q.size() != 0) check({nm, "_mhead"}, q[0], id * 4 + code);
    end
  endtask

  task automatic lovf(string nm, bit v);
    check({nm, "_ovf"}, int'(overflow_o), int'(v));
    check({nm, "_movf"}, int'(m_ovf), int'(v));
  endtask

  task automatic zero_out(string nm);
    check({nm, "_valid"}, int'(evt_valid_o), 0);
    check({nm, "_id"}, int'(evt_id_o), 0);
    check({nm, "_code"}, int'(evt_code_o), 0);
    check({nm, "_ovf"}, int'(overflow_o), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn_down_i = '0; btn_up_i = '0; evt_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    zero_out("rst");
    rst = 1'b0;
  endtask

  int del0, ovf0;

  initial begin
    repeat (3) @(negedge clk);
    zero_out("por");
    rst = 1'b0;

    // Short press on btn1
    do_reset();
    for (int t = 0; t <= 32; t++) begin
      @(negedge clk);
      btn_down_i = '0; btn_up_i = '0;
      if (t == 10) btn_down_i[1] = 1'b1;
      if (t == 14) btn_up_i[1] = 1'b1;
      if (t == 23) lit("short_t23", 0, 0, 0);
      if (t == 24) lit("short_t24", 1, 1, 1);
      if (t == 25) lit("short_t25", 0, 0, 0);
    end

    // Long press on btn0; the late release is silent
    do_reset();
    for (int t = 0; t <= 60; t++) begin
      @(negedge clk);
      btn_down_i = '0; btn_up_i = '0;
      if (t == 5)  btn_down_i[0] = 1'b1;
      if (t == 40) btn_up_i[0] = 1'b1;
      if (t == 22) lit("long_t22", 0, 0, 0);
      if (t == 23) lit("long_t23", 1, 0, 2);
      if (t == 24) lit("long_t24", 0, 0, 0);
      if (t == 55) lit("long_t55", 0, 0, 0);
    end

    // Double click with the second press at the GAP terminal cycle
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk);
      btn_down_i = '0; btn_up_i = '0;
      if (t == 0 || t == 11) btn_down_i[2] = 1'b1;
      if (t == 3 || t == 14) btn_up_i[2] = 1'b1;
      if (t == 12) lit("dbl_t12", 0, 0, 0);
      if (t == 13) lit("dbl_t13", 1, 2, 3);
      if (t == 14) lit("dbl_t14", 0, 0, 0);
      if (t == 25) lit("dbl_t25", 0, 0, 0);
    end

    // Release at the PRESS terminal cycle gives SHORT, not LONG
    do_reset();
    for (int t = 0; t <= 34; t++) begin
      @(negedge clk);
      btn_down_i = '0; btn_up_i = '0;
      if (t == 0)  btn_down_i[0] = 1'b1;
      if (t == 16) btn_up_i[0] = 1'b1;
      if (t == 18) lit("bnd_t18", 0, 0, 0);
      if (t == 25) lit("bnd_t25", 0, 0, 0);
      if (t == 26) lit("bnd_t26", 1, 0, 1);
    end

    // Arbitration under backpressure, then drain
    do_reset();
    del0 = n_del; ovf0 = n_ovf;
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk);
      btn_down_i = '0; btn_up_i = '0;
      evt_ready_i = (t >= 20);
      if (t == 2) btn_down_i = '1;
      if (t == 4) btn_up_i = '1;
      if (t == 13) lit("arb_t13", 0, 0, 0);
      if (t == 14) lit("arb_t14", 1, 0, 1);
      if (t == 17) lit("arb_t17", 1, 0, 1);
      if (t == 20) lit("arb_t20", 1, 0, 1);
      if (t == 21) lit("arb_t21", 1, 1, 1);
      if (t == 22) lit("arb_t22", 1, 2, 1);
      if (t == 23) lit("arb_t23", 0, 0, 0);
    end
    check("arb_delivered", n_del - del0, 3);
    check("arb_overflows", n_ovf - ovf0, 0);

    // Overflow: btn2 LONG while its SHORT is still pending
    do_reset();
    del0 = n_del; ovf0 = n_ovf;
    for (int t = 0; t <= 55; t++) begin
      @(negedge clk);
      btn_down_i = '0; btn_up_i = '0;
      evt_ready_i = (t >= 45);
      if (t == 2)  btn_down_i = '1;
      if (t == 4)  btn_up_i = '1;
      if (t == 20) btn_down_i[2] = 1'b1;
      if (t == 40) btn_up_i[2] = 1'b1;
      if (t == 36) lovf("ovf_t36", 0);
      if (t == 37) lovf("ovf_t37", 1);
      if (t == 38) lovf("ovf_t38", 0);
      if (t == 44) lit("ovf_t44", 1, 0, 1);
      if (t == 45) lit("ovf_t45", 1, 0, 1);
      if (t == 46) lit("ovf_t46", 1, 1, 1);
      if (t == 47) lit("ovf_t47", 1, 2, 1);
      if (t == 48) lit("ovf_t48", 0, 0, 0);
    end
    check("ovf_delivered", n_del - del0, 3);
    check("ovf_pulses", n_ovf - ovf0, 1);

    // Reset mid-PRESS with one event queued
    do_reset();
    del0 = n_del;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      btn_down_i = '0; btn_up_i = '0;
      evt_ready_i = (t >= 20);
      if (t == 0) btn_down_i[1] = 1'b1;
      if (t == 2) btn_up_i[1] = 1'b1;
      if (t == 8) btn_down_i[0] = 1'b1;
      if (t == 18) btn_up_i[0] = 1'b1;
      if (t == 14) begin lit("mrst_t14", 1, 1, 1); rst = 1'b1; end
      if (t == 15) begin zero_out("mrst_t15"); rst = 1'b0; end
      if (t == 40) lit("mrst_t40", 0, 0, 0);
    end
    check("mrst_delivered", n_del - del0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
